arm_fetch_unit: RTL and testbench

Instruction-fetch front end for the pipelined ARM core. Issues sequential word fetches to a variable-latency instruction memory and buffers returned words, with their PCs, in a small queue. Presents {PC, IC} to the IF/ID pipeline register through a valid/ready handshake. Accepts a branch redirect from the memory-stage branch unit (PCSrc, jump target), which flushes the queue and discards stale in-flight responses.

---
 rtl/arm_fetch_unit.sv | 125 ++++++++++++
 tb/tb_arm_fetch_unit.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arm_fetch_unit.sv
// Instruction-fetch front end: sequential word fetches to a variable-latency imem,
// in-order response queue toward IF/ID, and branch redirect with stale-response discard.
module arm_fetch_unit #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [63:0] RESET_PC        = 64'h0
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        ic_valid,
  input  logic        ic_ready,
  output logic [31:0] IC,
  output logic [63:0] PC
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned INF_W = $clog2(MAX_OUTSTANDING + 1);

  logic [63:0]      fetch_pc;
  logic [63:0]      resp_pc;
  logic [CNT_W-1:0] count;
  logic [INF_W-1:0] inflight;
  logic [INF_W-1:0] discard;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  logic [63:0] pc_q [DEPTH];
  logic [31:0] ic_q [DEPTH];

  logic        rsp_ok;
  logic        accept;
  logic        keep;
  logic        pop;
  logic        credit_ok;
  logic [63:0] target;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
  endfunction

  assign target = redirect_pc & ~64'h3;

  // A response with nothing outstanding is a protocol violation and is ignored outright.
  assign rsp_ok = imem_rvalid && (inflight != '0);

  // Queued plus in-flight never exceeds DEPTH, so every kept response has a free slot.
  assign credit_ok = (32'(inflight) < MAX_OUTSTANDING) &&
                     ((32'(inflight) + 32'(count)) < DEPTH);

  assign imem_req  = RESET && !redirect_valid && credit_ok;
  assign imem_addr = fetch_pc;
  assign accept    = imem_req && imem_gnt;
  assign keep      = rsp_ok && (discard == '0) && !redirect_valid;

  assign ic_valid = (count != '0);
  assign pop      = ic_valid && ic_ready && !redirect_valid;
  assign IC       = ic_valid ? ic_q[head] : '0;
  assign PC       = ic_valid ? pc_q[head] : '0;

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      count    <= '0;
      inflight <= '0;
      discard  <= '0;
      head     <= '0;
      tail     <= '0;
    end else if (redirect_valid) begin
      // Everything still outstanding after this cycle belongs to the old path.
      fetch_pc <= target;
      resp_pc  <= target;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
      inflight <= inflight - INF_W'(rsp_ok);
      discard  <= inflight - INF_W'(rsp_ok);
    end else begin
      if (accept) begin
        fetch_pc <= fetch_pc + 64'd4;
      end

      case ({accept, rsp_ok})
        2'b10:   inflight <= inflight + INF_W'(1);
        2'b01:   inflight <= inflight - INF_W'(1);
        default: inflight <= inflight;
      endcase

      if (rsp_ok) begin
        if (discard != '0) begin
          discard <= discard - INF_W'(1);
        end else begin
          resp_pc <= resp_pc + 64'd4;
          tail    <= ptr_inc(tail);
        end
      end

      if (pop) begin
        head <= ptr_inc(head);
      end

      case ({keep, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLOCK) begin
    if (keep) begin
      pc_q[tail] <= resp_pc;
      ic_q[tail] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_arm_fetch_unit.sv
// Bench for arm_fetch_unit: imem responder with random grant/latency, queue-based
// reference of expected fetch addresses and IF/ID contents, directed redirect/reset steps.
module tb_arm_fetch_unit;

  localparam int          DEPTH = 4;
  localparam int          MAXO  = 2;
  localparam logic [63:0] RPC   = 64'h0;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        ic_valid;
  logic        ic_ready = 1'b0;
  logic [31:0] IC;
  logic [63:0] PC;

  always #5 CLOCK = ~CLOCK;

  arm_fetch_unit #(
    .DEPTH(DEPTH),
    .MAX_OUTSTANDING(MAXO),
    .RESET_PC(RPC)
  ) dut (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .ic_valid(ic_valid),
    .ic_ready(ic_ready),
    .IC(IC),
    .PC(PC)
  );

  typedef struct {
    logic [63:0] addr;
    int          due;
    int          ep;
  } req_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] w;
  } ent_t;

  req_t        pend[$];
  ent_t        mq[$];
  logic [63:0] hs_log[$];
  logic [63:0] mfetch = RPC;
  int          epoch = 0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  int unsigned gnt_pct = 100, rv_pct = 100, rdy_pct = 100, redir_pct = 0;
  int unsigned lat_min = 0, lat_max = 0;
  bit          redir_once = 1'b0;
  bit          force_rv = 1'b0;
  logic [63:0] redir_target = '0;

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return (a[33:2] * 32'h9E37_79B1) ^ a[63:32] ^ 32'hA5A5_0F0F;
  endfunction

  function automatic logic [63:0] log_at(input int i);
    return (hs_log.size() > i) ? hs_log[i] : 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs at posedge+1, compare and advance the model at negedge.
  task automatic tick();
    req_t        e;
    req_t        r;
    ent_t        k;
    bit          kept;
    bit          exp_req;
    logic [63:0] exp_pc;
    logic [31:0] exp_ic;
    cyc++;
    if (redir_once) begin
      redirect_valid = 1'b1;
      redirect_pc    = redir_target;
      redir_once     = 1'b0;
    end else begin
      redirect_valid = ($urandom_range(99) < redir_pct);
      redirect_pc    = {$urandom, $urandom};
    end
    imem_gnt = ($urandom_range(99) < gnt_pct);
    if (force_rv) begin
      imem_rvalid = 1'b1;
      imem_rdata  = $urandom;
    end else if (pend.size() > 0 && pend[0].due <= cyc && $urandom_range(99) < rv_pct) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word_of(pend[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    ic_ready = ($urandom_range(99) < rdy_pct);

    @(negedge CLOCK);
    exp_req = RESET && !redirect_valid && (pend.size() < MAXO) &&
              (pend.size() + mq.size() < DEPTH);
    exp_pc  = (mq.size() > 0) ? mq[0].pc : 64'h0;
    exp_ic  = (mq.size() > 0) ? mq[0].w : 32'h0;
    chk("imem_req",  64'(imem_req), 64'(exp_req));
    chk("imem_addr", imem_addr, mfetch);
    chk("ic_valid",  64'(ic_valid), 64'(mq.size() > 0));
    chk("PC",        PC, exp_pc);
    chk("IC",        64'(IC), 64'(exp_ic));

    if (!RESET) begin
      pend.delete();
      mq.delete();
      mfetch = RPC;
    end else begin
      kept = 1'b0;
      if (imem_rvalid && pend.size() > 0) begin
        e = pend.pop_front();
        if (e.ep == epoch && !redirect_valid) begin
          kept = 1'b1;
          k.pc = e.addr;
          k.w  = imem_rdata;
        end
      end
      if (mq.size() > 0 && ic_ready && !redirect_valid) begin
        void'(mq.pop_front());
        hs_log.push_back(PC);
      end
      if (kept) mq.push_back(k);
      if (exp_req && imem_gnt) begin
        r.addr = mfetch;
        r.due  = cyc + 1 + int'($urandom_range(lat_max, lat_min));
        r.ep   = epoch;
        pend.push_back(r);
        mfetch = mfetch + 64'd4;
      end
      if (redirect_valid) begin
        mq.delete();
        epoch++;
        mfetch = {redirect_pc[63:2], 2'b00};
      end
    end
    @(posedge CLOCK);
    #1;
  endtask

  task automatic redirect_to(input logic [63:0] t);
    redir_target = t;
    redir_once   = 1'b1;
    tick();
  endtask

  initial begin
    int n0;
    // Reset held: all outputs at reset values.
    repeat (2) @(posedge CLOCK);
    #1;
    repeat (3) tick();

    // Release with IF/ID stalled: exactly DEPTH words queue up, then requests stop.
    RESET   = 1'b1;
    rdy_pct = 0;
    repeat (10) tick();
    chk("hold_head_pc", PC, 64'h0);
    chk("hold_req",     64'(imem_req), 64'h0);
    chk("hold_valid",   64'(ic_valid), 64'h1);

    // Release: in-order drain, then a bubble-free stream.
    rdy_pct = 100;
    hs_log.delete();
    repeat (6) tick();
    chk("drain_pc0", log_at(0), 64'h0);
    chk("drain_pc4", log_at(4), 64'h10);
    n0 = hs_log.size();
    repeat (10) tick();
    chk("no_bubble", 64'(hs_log.size() - n0), 64'd10);

    // Redirect with requests in flight and words queued.
    rdy_pct = 0;
    lat_min = 3;
    lat_max = 3;
    repeat (3) tick();
    hs_log.delete();
    redirect_to(64'h100);
    rdy_pct = 100;
    lat_min = 0;
    lat_max = 0;
    repeat (15) tick();
    chk("redir_first", log_at(0), 64'h100);

    // Redirect coinciding with a response; unaligned target.
    hs_log.delete();
    redirect_to(64'h103);
    chk("align_addr", imem_addr, 64'h100);
    repeat (10) tick();
    chk("align_first", log_at(0), 64'h100);

    // Address wrap at the top of the 64-bit space.
    hs_log.delete();
    redirect_to(64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    repeat (12) tick();
    chk("wrap_pc0", log_at(0), 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_pc1", log_at(1), 64'h0);
    chk("wrap_pc2", log_at(2), 64'h4);

    // Back-to-back redirects: the later one wins.
    hs_log.delete();
    lat_min = 1;
    lat_max = 2;
    redirect_to(64'h2000);
    redirect_to(64'h3000);
    repeat (15) tick();
    chk("b2b_first", log_at(0), 64'h3000);

    // Asynchronous reset mid-stream, then late responses with nothing outstanding.
    rdy_pct = 0;
    lat_min = 2;
    lat_max = 2;
    repeat (4) tick();
    chk("pre_rst_valid", 64'(ic_valid), 64'h1);
    #2;
    RESET = 1'b0;
    #1;
    chk("async_valid", 64'(ic_valid), 64'h0);
    chk("async_req",   64'(imem_req), 64'h0);
    chk("async_pc",    PC, 64'h0);
    pend.delete();
    mq.delete();
    mfetch = RPC;
    @(posedge CLOCK);
    #1;
    repeat (2) tick();
    RESET    = 1'b1;
    gnt_pct  = 0;
    force_rv = 1'b1;
    repeat (2) tick();
    force_rv = 1'b0;
    gnt_pct  = 100;
    rdy_pct  = 100;
    lat_min  = 0;
    lat_max  = 0;
    hs_log.delete();
    repeat (10) tick();
    chk("rst_first", log_at(0), RPC);
    chk("rst_second", log_at(1), RPC + 64'd4);

    // Randomized traffic against the reference model.
    for (int seg = 0; seg < 20; seg++) begin
      gnt_pct   = $urandom_range(100, 30);
      rv_pct    = $urandom_range(100, 30);
      rdy_pct   = $urandom_range(100, 20);
      redir_pct = $urandom_range(6, 0);
      lat_min   = 0;
      lat_max   = $urandom_range(4, 0);
      repeat (200) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
